// File: rtl/alu_pkg.sv
// Shared constants and types for the shift-ALU operand-fetch stage.
// Build option: define ALU_FWD_EN to forward same-cycle writeback data to the fetch read.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int OFF_W    = 4;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] operand;
    logic [OFF_W-1:0]  imm;
    logic [REG_AW-1:0] rd;
  } fetch_entry_t;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: one async read port, one sync write port, r0 hardwired to zero.
// Build option: ALU_FWD_EN returns same-cycle write data on an address match.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_raddr_zero;

  assign w_raddr_zero = (i_raddr == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // r0 is forced to zero on the read side so neither a write nor the bypass can leak into it.
  always_comb begin
    o_rdata = '0;
    if (!w_raddr_zero) begin
`ifdef ALU_FWD_EN
      if (i_we && (i_waddr == i_raddr)) begin
        o_rdata = i_wdata;
      end else begin
        o_rdata = r_mem[i_raddr];
      end
`else
      o_rdata = r_mem[i_raddr];
`endif
    end
  end

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the shift-right ALU: register-file read plus a 2-entry skid buffer.
// Build option: ALU_FWD_EN enables writeback-to-read bypass inside alu_regfile.
module alu_operand_fetch
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [OFF_W-1:0]  in_imm,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand1,
  output logic [OFF_W-1:0]  immediate_offset,
  output logic [REG_AW-1:0] out_rd,
  output buf_state_t        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // A producer holds its payload stable while valid is high and ready is low; in_ready
  // and out_valid are registers decoded from buffer occupancy only, so there is no
  // combinational path from out_ready back to in_ready.

  buf_state_t        r_state;
  fetch_entry_t      r_main;
  fetch_entry_t      r_skid;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] w_rf_rdata;
  fetch_entry_t      w_new;
  logic              w_accept;
  logic              w_consume;

  alu_regfile u_regfile (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_we    (wb_en),
    .i_waddr (wb_addr),
    .i_wdata (wb_data),
    .i_raddr (in_rs),
    .o_rdata (w_rf_rdata)
  );

  assign w_new     = '{operand: w_rf_rdata, imm: in_imm, rd: in_rd};
  assign w_accept  = in_valid && r_in_ready;
  assign w_consume = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main      <= w_new;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_accept && !w_consume) begin
            r_skid     <= w_new;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_consume && !w_accept) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_consume && w_accept) begin
            r_main <= w_new;
          end
        end
        FULL: begin
          // The skid entry is always older than anything upstream, so it refills main first.
          if (w_consume) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = r_in_ready;
  assign out_valid        = r_out_valid;
  assign operand1         = r_main.operand;
  assign immediate_offset = r_main.imm;
  assign out_rd           = r_main.rd;
  assign dbg_state        = r_state;

endmodule
